// File: rtl/maf_pkg.sv
// rtl/maf_pkg.sv - shared types, sizing constants and rounding helper for the moving average filter
package maf_pkg;

  typedef enum logic [0:0] {FILL, RUN} maf_state_t;

  localparam int MAF_DEF_DATA_WIDTH = 8;
  localparam int MAF_DEF_MAX_LOG2_N = 4;
  localparam int MAF_DEF_SUM_W      = MAF_DEF_DATA_WIDTH + MAF_DEF_MAX_LOG2_N;
  localparam int MAF_DEF_DEPTH      = 2 ** MAF_DEF_MAX_LOG2_N;

  // Rounding is done on a wide, already-extended copy of the sum so one helper
  // serves every parameterisation; callers truncate the result to their width.
  localparam int MAF_CALC_W = 64;

  function automatic logic [MAF_CALC_W-1:0] maf_round_shift(
    input logic [MAF_CALC_W-1:0] sum,
    input logic [7:0]            k,
    input logic                  signed_mode
  );
    logic [MAF_CALC_W-1:0] v;
    v = sum + ((k > 8'd0) ? (64'd1 << (k - 8'd1)) : 64'd0);
    if (signed_mode)
      maf_round_shift = $signed(v) >>> k;
    else
      maf_round_shift = v >> k;
  endfunction

endpackage

// File: rtl/maf_ring_buffer.sv
// rtl/maf_ring_buffer.sv - sample history memory, one write port and one asynchronous read port
module maf_ring_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/moving_average_filter_pw.sv
// rtl/moving_average_filter_pw.sv - power-of-two window moving average with fill tracking and rounded output
module moving_average_filter_pw
  import maf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOG2_N = 4,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [$clog2(MAX_LOG2_N+1)-1:0]    win_log2,
  input  logic                               cfg_load,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               busy_fill
);

  localparam int SUM_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int DEPTH = 2 ** MAX_LOG2_N;
  localparam int AW    = MAX_LOG2_N;
  localparam int KW    = $clog2(MAX_LOG2_N + 1);
  localparam logic [KW-1:0] K_MAX   = KW'(MAX_LOG2_N);
  localparam logic [AW:0]   WIN_ONE = 1;

  maf_state_t            r_state;
  logic [KW-1:0]         r_k;
  logic [AW-1:0]         r_wp;
  logic [AW:0]           r_fill_cnt;
  logic [SUM_W-1:0]      r_sum;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [AW:0]           w_win;
  logic [AW-1:0]         w_rd_addr;
  logic [DATA_WIDTH-1:0] w_old_raw;
  logic                  w_old_sign;
  logic                  w_in_sign;
  logic [SUM_W-1:0]      w_old_ext;
  logic [SUM_W-1:0]      w_in_ext;
  logic [SUM_W-1:0]      w_sum_next;
  logic                  w_sum_sign;
  logic [MAF_CALC_W-1:0] w_sum_wide;
  logic [DATA_WIDTH-1:0] w_avg;
  logic [AW:0]           w_fill_next;
  logic                  w_run_after;
  logic                  w_accept;
  logic [KW-1:0]         w_k_clamped;

  assign w_win       = WIN_ONE << r_k;
  // With W equal to the full depth the oldest sample sits at wp itself.
  assign w_rd_addr   = r_wp - w_win[AW-1:0];
  assign w_accept    = in_valid & ~cfg_load;
  assign w_k_clamped = (win_log2 > K_MAX) ? K_MAX : win_log2;

  maf_ring_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ring_buffer (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wp),
    .i_wr_data (data_in),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_old_raw)
  );

  assign w_in_sign  = SIGNED & data_in[DATA_WIDTH-1];
  assign w_old_sign = SIGNED & w_old_raw[DATA_WIDTH-1];
  assign w_in_ext   = {{MAX_LOG2_N{w_in_sign}}, data_in};
  // Until the window has been filled the read slot holds stale data from before the flush.
  assign w_old_ext  = (r_fill_cnt < w_win) ? '0 : {{MAX_LOG2_N{w_old_sign}}, w_old_raw};
  assign w_sum_next = r_sum + w_in_ext - w_old_ext;

  assign w_sum_sign = SIGNED & w_sum_next[SUM_W-1];
  assign w_sum_wide = {{(MAF_CALC_W-SUM_W){w_sum_sign}}, w_sum_next};
  assign w_avg      = DATA_WIDTH'(maf_round_shift(w_sum_wide, 8'(r_k), SIGNED));

  assign w_fill_next = r_fill_cnt + 1'b1;
  assign w_run_after = (r_state == RUN) || (w_fill_next == w_win);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= FILL;
      r_k         <= '0;
      r_wp        <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else if (cfg_load) begin
      r_state     <= FILL;
      r_k         <= w_k_clamped;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        r_wp  <= r_wp + 1'b1;
        r_sum <= w_sum_next;
        case (r_state)
          FILL: begin
            r_fill_cnt <= w_fill_next;
            if (w_fill_next == w_win)
              r_state <= RUN;
          end
          RUN: r_state <= RUN;
          default: r_state <= FILL;
        endcase
        if (w_run_after) begin
          r_out_valid <= 1'b1;
          r_data_out  <= w_avg;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign busy_fill = (r_state == FILL);

endmodule

// File: tb/tb_moving_average_filter_pw.sv
// tb/tb_moving_average_filter_pw.sv - self-checking bench for unsigned and signed filter instances
module tb_moving_average_filter_pw;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [2:0] win = 3'd0;
  logic       cfg_load = 1'b0;

  logic       u_ov, u_busy, s_ov, s_busy;
  logic [7:0] u_do, s_do;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  moving_average_filter_pw #(.DATA_WIDTH(8), .MAX_LOG2_N(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .data_in(data_in),
    .win_log2(win), .cfg_load(cfg_load),
    .out_valid(u_ov), .data_out(u_do), .busy_fill(u_busy)
  );

  moving_average_filter_pw #(.DATA_WIDTH(8), .MAX_LOG2_N(4), .SIGNED(1'b1)) s_dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .data_in(data_in),
    .win_log2(win), .cfg_load(cfg_load),
    .out_valid(s_ov), .data_out(s_do), .busy_fill(s_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: samples accepted since the last flush, averaged over the last W with round-half-up.
  int         q[$];
  int         mk = 0;
  logic       m_ov = 1'b0;
  logic       m_busy = 1'b1;
  logic [7:0] m_du = 8'd0;
  logic [7:0] m_ds = 8'd0;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int window_avg(input bit sgn);
    int w, s, v;
    w = 1 << mk;
    s = 0;
    for (int i = 0; i < w; i++) begin
      v = q[q.size() - w + i];
      if (sgn && v > 127) v = v - 256;
      s += v;
    end
    return floor_div(s + w / 2, w);
  endfunction

  initial forever begin
    @(posedge clk or posedge areset);
    if (areset) begin
      q.delete();
      mk = 0; m_ov = 1'b0; m_busy = 1'b1; m_du = 8'd0; m_ds = 8'd0;
    end else if (cfg_load) begin
      q.delete();
      mk = (win > 3'd4) ? 4 : int'(win);
      m_ov = 1'b0; m_busy = 1'b1;
    end else if (in_valid) begin
      q.push_back(int'(data_in));
      if (q.size() > 16) void'(q.pop_front());
      if (q.size() >= (1 << mk)) begin
        m_ov = 1'b1; m_busy = 1'b0;
        m_du = 8'(window_avg(1'b0));
        m_ds = 8'(window_avg(1'b1));
      end else begin
        m_ov = 1'b0;
      end
    end else begin
      m_ov = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_u_out_valid", u_ov, m_ov);
    chk("cmp_u_busy_fill", u_busy, m_busy);
    chk("cmp_u_data_out", u_do, m_du);
    chk("cmp_s_out_valid", s_ov, m_ov);
    chk("cmp_s_busy_fill", s_busy, m_busy);
    chk("cmp_s_data_out", s_do, m_ds);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; cfg_load = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; data_in = d; cfg_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [2:0] w, input logic v, input logic [7:0] d);
    @(negedge clk);
    cfg_load = 1'b1; win = w; in_valid = v; data_in = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] gap_vals [6];

  initial begin
    gap_vals = '{8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30};
    #3;
    chk("reset_data_out", u_do, 8'd0);
    chk("reset_out_valid", u_ov, 1'b0);
    chk("reset_busy_fill", u_busy, 1'b1);
    @(negedge clk);
    areset = 1'b0;

    // W=1 straight out of reset
    send(8'd77);
    chk("w1_out_valid", u_ov, 1'b1);
    chk("w1_data_out", u_do, 8'd77);
    idle(1);

    // W=4 fill
    cfg(3'd2, 1'b0, 8'd0);
    send(8'd10); send(8'd20); send(8'd30);
    chk("fill3_out_valid", u_ov, 1'b0);
    chk("fill3_busy_fill", u_busy, 1'b1);
    send(8'd40);
    chk("fill4_out_valid", u_ov, 1'b1);
    chk("fill4_busy_fill", u_busy, 1'b0);
    chk("fill4_data_out", u_do, 8'd25);
    send(8'd50);
    chk("run5_data_out", u_do, 8'd35);
    idle(2);

    // Rounding, W=2
    cfg(3'd1, 1'b0, 8'd0);
    send(8'd3); send(8'd4);
    chk("round_u_data_out", u_do, 8'd4);
    cfg(3'd1, 1'b0, 8'd0);
    send(8'hFD); send(8'hFC);
    chk("round_s_out_valid", s_ov, 1'b1);
    chk("round_s_data_out", s_do, 8'hFD);
    idle(1);

    // W=16 via clamped win_log2, full-scale samples
    cfg(3'd7, 1'b0, 8'd0);
    repeat (15) send(8'd255);
    chk("w16_fill15_out_valid", u_ov, 1'b0);
    send(8'd255);
    chk("w16_out_valid", u_ov, 1'b1);
    chk("w16_data_out", u_do, 8'd255);
    send(8'd0);
    chk("w16_after_zero", u_do, 8'd239);
    idle(1);

    // cfg_load colliding with a sample mid-RUN
    cfg(3'd2, 1'b0, 8'd0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    chk("pre_flush_data_out", u_do, 8'd3);
    cfg(3'd1, 1'b1, 8'd99);
    chk("flush_busy_fill", u_busy, 1'b1);
    chk("flush_out_valid", u_ov, 1'b0);
    chk("flush_holds_data", u_do, 8'd3);
    send(8'd8);
    chk("flush_first_out_valid", u_ov, 1'b0);
    send(8'd6);
    chk("flush_second_out_valid", u_ov, 1'b1);
    chk("flush_data_out", u_do, 8'd7);

    // Gapped stream, W=4
    cfg(3'd2, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      send(gap_vals[i]);
      if (i >= 3) chk("gap_out_valid_hi", u_ov, 1'b1);
      if (i == 3) chk("gap_data_out", u_do, 8'd13);
      idle(1);
      @(posedge clk); #1;
      chk("gap_out_valid_lo", u_ov, 1'b0);
    end

    // Asynchronous reset in RUN
    send(8'd100);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    chk("areset_data_out", u_do, 8'd0);
    chk("areset_out_valid", u_ov, 1'b0);
    chk("areset_busy_fill", u_busy, 1'b1);
    chk("areset_s_data_out", s_do, 8'd0);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle_out_valid", u_ov, 1'b0);
    cfg(3'd2, 1'b0, 8'd0);
    send(8'd40); send(8'd40); send(8'd40);
    chk("refill3_out_valid", u_ov, 1'b0);
    send(8'd41);
    chk("refill4_out_valid", u_ov, 1'b1);
    chk("refill4_data_out", u_do, 8'd40);

    // Mixed stream, W=8, both signednesses against the model
    cfg(3'd3, 1'b0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 2) begin
        idle(1);
        @(posedge clk); #1;
      end else begin
        send(8'((i * 37 + 11) & 255));
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
